bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 21 ++
 rtl/bin_to_bcd_seq.sv | 119 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   BCD_DIGIT_W    : bits per BCD digit
//   ADD3_THRESHOLD : digit value at or above which double dabble adds 3
//   bcd_state_e    : converter FSM state encoding (ST_IDLE, ST_SHIFT)
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam logic [3:0]  ADD3_THRESHOLD = 4'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } bcd_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble adjust: digits of 5..9 get +3 so that the following
// left shift carries correctly into the next decimal digit.
//   digit_i : current BCD scratch digit
//   digit_o : adjusted digit (digit_i >= 5 ? digit_i + 3 : digit_i)
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Inputs never exceed 9, so the sum stays <= 12 and needs no carry out.
    always_comb begin
        if (digit_i >= ADD3_THRESHOLD) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Ports:
//   CLK_IN  : clock, rising-edge active
//   RST     : synchronous active-high reset
//   START   : conversion request, sampled only while idle
//   BIN_IN  : binary operand, latched on the accepting edge
//   BUSY    : conversion in progress
//   DONE    : one-cycle pulse when BCD_OUT/BLANK update
//   BCD_OUT : result, digit k at [4k+3:4k], digit 0 least significant
//   BLANK   : bit k high when digit k is a leading zero (bit 0 always low)
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          CLK_IN,
    input  logic                          RST,
    input  logic                          START,
    input  logic [WIDTH-1:0]              BIN_IN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [BCD_DIGIT_W*DIGITS-1:0] BCD_OUT,
    output logic [DIGITS-1:0]             BLANK
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // All digits except the least significant one blanked, so zero shows "0".
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    bcd_state_e         state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   shift_d;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   scratch_d;
    logic [BCD_W-1:0]   adjusted;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [DIGITS-1:0]  blank_q;
    logic [DIGITS-1:0]  blank_d;

    // Per-digit add-3 adjust ahead of the shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .digit_o (adjusted[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // Shift {adjusted, shift_q} left by one: shift_q MSB enters the scratch LSB.
    always_comb begin
        scratch_d = {adjusted[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
    end

    // Leading-zero flags from the post-shift scratch, scanned from the top digit down.
    always_comb begin
        logic nz;
        nz      = 1'b0;
        blank_d = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            nz         = nz | (scratch_d[BCD_DIGIT_W*k +: BCD_DIGIT_W] != '0);
            blank_d[k] = ~nz;
        end
        blank_d[0] = 1'b0;
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        shift_q   <= BIN_IN;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= scratch_d;
                        blank_q <= blank_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign BCD_OUT = bcd_q;
    assign BLANK   = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3). Expected results are
// queued when a conversion is started and checked by a monitor on each DONE pulse.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [11:0] bcd;
        logic [2:0]  blank;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic [2:0]  blank;

    int          checks;
    int          failures;
    exp_t        sb[$];
    logic [11:0] hold_exp;

    bin_to_bcd_seq #(
        .WIDTH  (8),
        .DIGITS (3)
    ) dut (
        .CLK_IN  (clk),
        .RST     (rst),
        .START   (start),
        .BIN_IN  (bin_in),
        .BUSY    (busy),
        .DONE    (done),
        .BCD_OUT (bcd_out),
        .BLANK   (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input int v);
        exp_t e;
        e.bcd   = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        e.blank = {v < 100, v < 10, 1'b0};
        return e;
    endfunction

    // Scoreboard monitor plus hold-while-busy check, sampled on the falling edge.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done bcd=%h (no conversion outstanding)", bcd_out);
            end else begin
                e = sb.pop_front();
                if (bcd_out !== e.bcd) begin
                    failures++;
                    $display("FAIL result_bcd got=%h exp=%h", bcd_out, e.bcd);
                end
                checks++;
                if (blank !== e.blank) begin
                    failures++;
                    $display("FAIL result_blank got=%b exp=%b", blank, e.blank);
                end
                hold_exp = e.bcd;
            end
        end else if (busy === 1'b1) begin
            checks++;
            if (bcd_out !== hold_exp) begin
                failures++;
                $display("FAIL hold_while_busy got=%h exp=%h", bcd_out, hold_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives START for one edge (the accepting edge E); returns at E+#1.
    task automatic start_conv(input int v);
        start  = 1'b1;
        bin_in = 8'(v);
        sb.push_back(model(v));
        tick();
        start  = 1'b0;
        bin_in = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (done !== 1'b1 && lat < 40);
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=8", name, lat);
        end
    endtask

    task automatic count_done(input string name, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL %s_spurious_done got=%0d exp=0", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 4;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        if (done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b exp=0", done);
        end
        if (bcd_out !== 12'h000) begin
            failures++; $display("FAIL reset_bcd got=%h exp=000", bcd_out);
        end
        if (blank !== 3'b110) begin
            failures++; $display("FAIL reset_blank got=%b exp=110", blank);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_boundary();
        int lat;
        start_conv(0);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL busy_after_start got=%b exp=1", busy);
        end
        wait_done("zero", lat);
        tick();
        start_conv(255);
        wait_done("max", lat);
        tick();
    endtask

    task automatic test_fibonacci();
        int lat;
        int vals[4] = '{1, 13, 89, 233};
        foreach (vals[i]) begin
            start_conv(vals[i]);
            wait_done("fib", lat);
            tick();
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        start_conv(200);
        n = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin
                start  = 1'b1;
                bin_in = 8'd7;
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) n++;
            if (c == 8) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++; $display("FAIL busy_start_done got=%b exp=1", done);
                end
            end
        end
        count_done("busy_start", 12);
        checks++;
        if (n != 1) begin
            failures++; $display("FAIL busy_start_done_count got=%0d exp=1", n);
        end
    endtask

    // START held through the DONE cycle: the next conversion is accepted on the
    // edge that ends the DONE cycle (E+9), so its DONE follows at E+17.
    task automatic test_back_to_back();
        int first;
        int second;
        first  = -1;
        second = -1;
        start  = 1'b1;
        bin_in = 8'd144;
        sb.push_back(model(144));
        tick();
        bin_in = 8'd55;
        sb.push_back(model(55));
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 9) start = 1'b0;
            if (done === 1'b1) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        checks += 2;
        if (first != 8) begin
            failures++; $display("FAIL b2b_first_done got=%0d exp=8", first);
        end
        if (second != 17) begin
            failures++; $display("FAIL b2b_second_done got=%0d exp=17", second);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_conv(99);
        tick();
        tick();
        rst = 1'b1;
        tick();
        sb.delete();
        hold_exp = 12'h000;
        checks += 4;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL midrst_busy got=%b exp=0", busy);
        end
        if (done !== 1'b0) begin
            failures++; $display("FAIL midrst_done got=%b exp=0", done);
        end
        if (bcd_out !== 12'h000) begin
            failures++; $display("FAIL midrst_bcd got=%h exp=000", bcd_out);
        end
        if (blank !== 3'b110) begin
            failures++; $display("FAIL midrst_blank got=%b exp=110", blank);
        end
        tick();
        rst = 1'b0;
        count_done("midrst", 12);
        start_conv(21);
        wait_done("after_rst", lat);
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        hold_exp = 12'h000;
        rst      = 1'b1;
        start    = 1'b0;
        bin_in   = 8'd0;
        test_reset();
        test_boundary();
        test_fibonacci();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
